modmul_arbiter: RTL and testbench

Round-robin arbiter that shares one `g` modular multiplier (result = a·b mod m, 260-bit operands) among `N` requesters. It sits beside exponentiation and other sequencing blocks that currently instantiate their own `g`, and replaces those private copies with one shared instance. It owns the multiplier's start/done handshake and returns each product to the requester that issued it.

---
 rtl/modmul_pkg.sv | 33 +++
 rtl/modmul_arbiter_if.sv | 20 ++
 rtl/g.sv | 63 ++++++
 rtl/modmul_arbiter.sv | 99 +++++++++
 tb/tb_modmul_arbiter.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/modmul_pkg.sv
// Shared types for the modular-multiplier arbiter: widths, FSM state encoding and
// the round-robin pick helper.
package modmul_pkg;

    localparam int unsigned MODMUL_W = 260;
    localparam int unsigned MAX_N    = 8;

    typedef enum logic [2:0] {IDLE, LOAD, START, DROP, POLL, RESP} state_e;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } rr_pick_t;

    // First set bit at or above ptr, wrapping modulo n (n <= MAX_N).
    function automatic rr_pick_t rr_pick(input logic [MAX_N-1:0] req,
                                         input logic [2:0]       ptr,
                                         input int unsigned      n);
        rr_pick_t    r;
        int unsigned j;
        r = '0;
        for (int unsigned k = 0; k < MAX_N; k++) begin
            j = {29'd0, ptr} + k;
            if (j >= n) j = j - n;
            if (!r.found && k < n && req[j[2:0]]) begin
                r.found = 1'b1;
                r.idx   = j[2:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/modmul_arbiter_if.sv
// Requester-side bundle of the shared modular multiplier: packed operands in,
// per-requester ack/response pulses and a shared result bus out.
interface modmul_arbiter_if
    import modmul_pkg::*;
#(
    parameter int unsigned N = 4,
    parameter int unsigned W = MODMUL_W
);
    logic [N-1:0]   req;
    logic [N*W-1:0] a;
    logic [N*W-1:0] b;
    logic [N*W-1:0] m;
    logic [N-1:0]   ack;
    logic [N-1:0]   rsp_valid;
    logic [W-1:0]   result;
    logic           busy;

    modport master (output req, a, b, m, input ack, rsp_valid, result, busy);
    modport slave  (input req, a, b, m, output ack, rsp_valid, result, busy);
endinterface

// File: rtl/g.sv
// Interleaved shift-add modular multiplier: result = a*b mod m in W cycles.
// Expects a < m; done is a level that drops on start and rises with the result.
module g
    import modmul_pkg::*;
#(
    parameter int unsigned W = MODMUL_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] m,
    output logic [W-1:0] result,
    output logic         done
);
    localparam int unsigned CW = $clog2(W + 1);

    logic [W-1:0]  a_q, b_q, m_q, acc_q, acc_next;
    logic [CW-1:0] cnt_q;
    logic          run_q, done_q;
    logic [W+1:0]  dbl, t1, t2, m_ext;

    // acc < m throughout, so each step needs at most one subtraction after each add.
    always_comb begin
        m_ext    = {2'b00, m_q};
        dbl      = {1'b0, acc_q, 1'b0};
        t1       = (dbl >= m_ext) ? dbl - m_ext : dbl;
        t2       = b_q[W-1] ? t1 + {2'b00, a_q} : t1;
        acc_next = (t2 >= m_ext) ? W'(t2 - m_ext) : W'(t2);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q    <= '0;
            b_q    <= '0;
            m_q    <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else if (start) begin
            a_q    <= a;
            b_q    <= b;
            m_q    <= m;
            acc_q  <= '0;
            cnt_q  <= CW'(W);
            run_q  <= 1'b1;
            done_q <= 1'b0;
        end else if (run_q) begin
            acc_q <= acc_next;
            b_q   <= b_q << 1;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                run_q  <= 1'b0;
                done_q <= 1'b1;
            end
        end
    end

    assign result = acc_q;
    assign done   = done_q;
endmodule

// File: rtl/modmul_arbiter.sv
// Round-robin arbiter sharing one g modular multiplier among N requesters; owns the
// start/done handshake and routes each product back to its issuer.
module modmul_arbiter
    import modmul_pkg::*;
#(
    parameter int unsigned N = 4,
    parameter int unsigned W = MODMUL_W
) (
    input  logic            clk,
    input  logic            reset,
    modmul_arbiter_if.slave bus
);
    localparam int unsigned  GW  = $clog2(N);
    localparam logic [N-1:0] ONE = N'(1);

    logic [1:0]    rst_sync;
    logic          rst_int;
    state_e        state_q;
    logic [GW-1:0] ptr_q, gnt_q;
    logic [W-1:0]  op_a, op_b, op_m, result_q, mm_result;
    logic          mm_start, mm_done;
    logic [N-1:0]  ack_q, rsp_q;
    rr_pick_t      pick;

    // Assert asynchronously, release on the second clock edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_int = rst_sync[1];

    always_comb pick = rr_pick(MAX_N'(bus.req), 3'(ptr_q), N);

    always_ff @(posedge clk or negedge rst_int) begin
        if (!rst_int) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            gnt_q    <= '0;
            op_a     <= '0;
            op_b     <= '0;
            op_m     <= '0;
            mm_start <= 1'b0;
            ack_q    <= '0;
            rsp_q    <= '0;
            result_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: if (pick.found) begin
                    gnt_q   <= GW'(pick.idx);
                    state_q <= LOAD;
                end
                LOAD: begin
                    op_a    <= bus.a[int'(gnt_q) * W +: W];
                    op_b    <= bus.b[int'(gnt_q) * W +: W];
                    op_m    <= bus.m[int'(gnt_q) * W +: W];
                    ack_q   <= ONE << gnt_q;
                    state_q <= START;
                end
                START: begin
                    mm_start <= 1'b1;
                    ack_q    <= '0;
                    state_q  <= DROP;
                end
                // Lets g see a single start pulse and clear done before POLL samples it.
                DROP: begin
                    mm_start <= 1'b0;
                    state_q  <= POLL;
                end
                POLL: if (mm_done) begin
                    result_q <= mm_result;
                    rsp_q    <= ONE << gnt_q;
                    state_q  <= RESP;
                end
                RESP: begin
                    rsp_q   <= '0;
                    ptr_q   <= (gnt_q == GW'(N - 1)) ? '0 : gnt_q + GW'(1);
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    g #(.W(W)) u_g (
        .clk   (clk),
        .reset (~reset),
        .start (mm_start),
        .a     (op_a),
        .b     (op_b),
        .m     (op_m),
        .result(mm_result),
        .done  (mm_done)
    );

    assign bus.ack       = ack_q;
    assign bus.rsp_valid = rsp_q;
    assign bus.result    = result_q;
    assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_modmul_arbiter.sv
// Directed bench for modmul_arbiter: hand-computed products, grant order and
// reset behaviour observed through a per-cycle ack/response log.
module tb_modmul_arbiter;
    import modmul_pkg::*;

    localparam int unsigned N = 4;
    localparam int unsigned W = MODMUL_W;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    modmul_arbiter_if #(.N(N), .W(W)) bus ();
    modmul_arbiter #(.N(N), .W(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    int           checks = 0, failures = 0;
    int           ack_log[$], rsp_log[$];
    logic [W-1:0] res_log[$];
    int           outstanding = -1, overlap_err = 0, order_err = 0;
    bit           hold = 1'b0;
    int           exp_seq[6];
    logic [W-1:0] exp_res[4];
    logic [W-1:0] wide_m, wide_a;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [W-1:0] mv);
        bus.a[i*W +: W] = av;
        bus.b[i*W +: W] = bv;
        bus.m[i*W +: W] = mv;
    endtask

    task automatic clear_logs();
        ack_log.delete();
        rsp_log.delete();
        res_log.delete();
        outstanding = -1;
        overlap_err = 0;
        order_err   = 0;
    endtask

    // One cycle: log pulses, track ack->rsp pairing, release req on ack unless holding.
    task automatic sample();
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (bus.ack[i]) begin
                ack_log.push_back(i);
                if (outstanding >= 0) overlap_err++;
                outstanding = i;
                if (!hold) bus.req[i] = 1'b0;
            end
            if (bus.rsp_valid[i]) begin
                rsp_log.push_back(i);
                res_log.push_back(bus.result);
                if (outstanding != i) order_err++;
                outstanding = -1;
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) sample();
    endtask

    task automatic run(input string tag, input int target, input int budget);
        for (int c = 0; c < budget && rsp_log.size() < target; c++) sample();
        check(tag, rsp_log.size(), target);
    endtask

    function automatic int ack_at(input int k);
        return (k < ack_log.size()) ? ack_log[k] : -1;
    endfunction

    function automatic int rsp_at(input int k);
        return (k < rsp_log.size()) ? rsp_log[k] : -1;
    endfunction

    function automatic logic [W-1:0] res_at(input int k);
        return (k < res_log.size()) ? res_log[k] : '1;
    endfunction

    task automatic do_reset();
        bus.req = '0;
        reset   = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        clear_logs();
        hold = 1'b0;
    endtask

    initial begin
        reset   = 1'b0;
        bus.req = '0;
        bus.a   = '0;
        bus.b   = '0;
        bus.m   = '0;
        exp_seq = '{0, 1, 2, 3, 0, 1};
        repeat (3) @(negedge clk);
        check("rst_ack", bus.ack, 0);
        check("rst_rsp", bus.rsp_valid, 0);
        check("rst_result", bus.result, 0);
        check("rst_busy", bus.busy, 0);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // Single request: 7*9 mod 11 = 8.
        set_op(0, 7, 9, 11);
        bus.req = 4'b0001;
        run("t1_done", 1, 400);
        tick(1);
        check("t1_busy_low", bus.busy, 0);
        tick(3);
        check("t1_ack_count", ack_log.size(), 1);
        check("t1_ack_idx", ack_at(0), 0);
        check("t1_rsp_idx", rsp_at(0), 0);
        check("t1_result", res_at(0), 8);

        // Simultaneous 0 and 2 from ptr=0: 12 mod 5 = 2, 36 mod 7 = 1.
        do_reset();
        set_op(0, 3, 4, 5);
        set_op(2, 6, 6, 7);
        bus.req = 4'b0101;
        run("t2_done", 2, 800);
        check("t2_grant0", ack_at(0), 0);
        check("t2_grant1", ack_at(1), 2);
        check("t2_rsp0", rsp_at(0), 0);
        check("t2_rsp1", rsp_at(1), 2);
        check("t2_res0", res_at(0), 2);
        check("t2_res1", res_at(1), 1);

        // All requests held: rotation 0,1,2,3,0,1 with (i+2)*5 mod 13.
        do_reset();
        exp_res = '{10, 2, 7, 12};
        for (int i = 0; i < N; i++) set_op(i, i + 2, 5, 13);
        hold    = 1'b1;
        bus.req = 4'b1111;
        run("t3_done", 6, 2000);
        bus.req = '0;
        hold    = 1'b0;
        tick(5);
        check("t3_ack_count", ack_log.size(), 6);
        for (int k = 0; k < 6; k++) begin
            check("t3_grant", ack_at(k), exp_seq[k]);
            check("t3_rsp", rsp_at(k), exp_seq[k]);
            check("t3_res", res_at(k), exp_res[exp_seq[k]]);
        end
        check("t3_overlap", overlap_err, 0);
        check("t3_order", order_err, 0);

        // (2^259)^2 mod (2^259+1) = 1.
        do_reset();
        wide_a      = '0;
        wide_a[259] = 1'b1;
        wide_m      = wide_a + 1;
        set_op(3, wide_a, wide_a, wide_m);
        bus.req = 4'b1000;
        run("t4_done", 1, 400);
        check("t4_rsp_idx", rsp_at(0), 3);
        check("t4_result", res_at(0), 1);

        // Reset during POLL discards the operation; result bus still holds 1 beforehand.
        tick(2);
        clear_logs();
        set_op(0, 7, 9, 11);
        bus.req = 4'b0001;
        for (int c = 0; c < 20 && ack_log.size() == 0; c++) sample();
        check("t5_ack", ack_log.size(), 1);
        tick(10);
        check("t5_busy_pre", bus.busy, 1);
        check("t5_result_pre", bus.result, 1);
        bus.req = '0;
        reset   = 1'b0;
        #1;
        check("t5_rst_ack", bus.ack, 0);
        check("t5_rst_rsp", bus.rsp_valid, 0);
        check("t5_rst_result", bus.result, 0);
        check("t5_rst_busy", bus.busy, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        clear_logs();
        tick(300);
        check("t5_no_rsp", rsp_log.size(), 0);
        set_op(1, 2, 5, 7);
        bus.req = 4'b0010;
        run("t5_fresh_done", 1, 400);
        check("t5_fresh_idx", rsp_at(0), 1);
        check("t5_fresh_res", res_at(0), 3);

        // req[1] dropped right after IDLE samples it: 16 mod 9 = 7.
        tick(2);
        clear_logs();
        set_op(1, 4, 4, 9);
        bus.req = 4'b0010;
        sample();
        bus.req = '0;
        run("t6_done", 1, 400);
        check("t6_ack_idx", ack_at(0), 1);
        check("t6_rsp_idx", rsp_at(0), 1);
        check("t6_result", res_at(0), 7);
        tick(1);
        check("t6_busy_low", bus.busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
